// File: rtl/apb_top_module.sv
// APB master FSM driving an internal 256x8 register-file slave.
// Define APB_WAIT_STATE_EN to insert WAIT_STATES slave wait cycles per access.
module apb_top_module #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  transfer,
  input  logic                  read_write,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_nxt;
  logic                  psel, penable, wait_done, capture;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk or negedge preset)
    if (!preset) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (transfer) begin
        state_nxt = SETUP;
        capture   = 1'b1;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          state_nxt = transfer ? SETUP : IDLE;
          capture   = transfer;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched only when entering SETUP; later input churn is ignored.
  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (capture) begin
      pwrite <= read_write;
      paddr  <= read_write ? apb_write_paddr : apb_read_paddr;
      pwdata <= apb_write_data;
    end

`ifdef APB_WAIT_STATE_EN
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  logic [CW-1:0] wait_cnt;

  // Counts ACCESS cycles; cleared outside ACCESS and on completion.
  always_ff @(posedge pclk or negedge preset)
    if (!preset)                             wait_cnt <= '0;
    else if (state == ACCESS && !wait_done)  wait_cnt <= wait_cnt + CW'(1);
    else                                     wait_cnt <= '0;

  assign wait_done = (wait_cnt == CW'(WAIT_STATES));
`else
  assign wait_done = 1'b1;
`endif

  assign pready = psel & penable & wait_done;

  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pready && pwrite) begin
      mem[paddr] <= pwdata;
    end

  always_ff @(posedge pclk or negedge preset)
    if (!preset)                 prdata <= '0;
    else if (pready && !pwrite)  prdata <= mem[paddr];

endmodule

// File: tb/tb_apb_top_module.sv
// Randomized bench for apb_top_module against an array-based memory model.
module tb_apb_top_module;
`ifdef APB_WAIT_STATE_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic       pclk = 1'b0, preset = 1'b0;
  logic       transfer = 1'b0, read_write = 1'b0;
  logic [7:0] apb_write_paddr = '0, apb_write_data = '0, apb_read_paddr = '0;
  logic       pready;
  logic [7:0] prdata;

  apb_top_module #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(2)) dut (
    .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct { bit rw; bit [7:0] a; bit [7:0] d; } req_t;

  bit [7:0] mdl_mem [256];
  bit [7:0] mdl_prd;
  req_t     q[$];
  int       errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;
    mdl_prd = 8'h00;
  endtask

  task automatic drive(input req_t r);
    transfer        = 1'b1;
    read_write      = r.rw;
    apb_write_paddr = r.rw ? r.a : 8'($urandom);
    apb_read_paddr  = r.rw ? 8'($urandom) : r.a;
    apb_write_data  = r.d;
  endtask

  task automatic scramble(input bit keep_transfer);
    transfer        = keep_transfer ? 1'b1 : 1'($urandom);
    read_write      = 1'($urandom);
    apb_write_paddr = 8'($urandom);
    apb_read_paddr  = 8'($urandom);
    apb_write_data  = 8'($urandom);
  endtask

  // Issues every queued request back-to-back, then lets the bus go idle.
  task automatic run_burst(input string tag);
    int n;
    if (q.size() == 0) return;
    @(negedge pclk);
    drive(q[0]);
    @(posedge pclk); #1;
    for (int i = 0; i < q.size(); i++) begin
      chk({tag, "_setup_rdy"}, pready, 1'b0);
      scramble(1'b0);
      n = 0;
      do begin
        @(posedge pclk); #1; n++;
      end while (!pready && n < 20);
      chk({tag, "_latency"}, n, WS + 1);
      if (i + 1 < q.size()) drive(q[i+1]);
      else begin scramble(1'b0); transfer = 1'b0; end
      @(posedge pclk); #1;
      if (q[i].rw) mdl_mem[q[i].a] = q[i].d;
      else         mdl_prd = mdl_mem[q[i].a];
      chk({tag, "_prdata"}, prdata, mdl_prd);
    end
    @(posedge pclk); #1;
    chk({tag, "_idle_rdy"}, pready, 1'b0);
    q.delete();
  endtask

  function automatic req_t mk(input bit rw, input bit [7:0] a, input bit [7:0] d);
    req_t r;
    r.rw = rw; r.a = a; r.d = d;
    return r;
  endfunction

  initial begin
    bit [7:0] pool [6];
    pool[0] = 8'h00; pool[1] = 8'hFF; pool[2] = 8'h10;
    pool[3] = 8'h7E; pool[4] = 8'h81; pool[5] = 8'h33;
    mdl_reset();
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pready", pready, 1'b0);
    chk("rst_prdata", prdata, 8'h00);
    @(negedge pclk); preset = 1'b1;
    @(posedge pclk); #1;
    chk("post_rst_pready", pready, 1'b0);

    q.push_back(mk(1, 8'h10, 8'hA5)); run_burst("wr10");
    q.push_back(mk(0, 8'h10, 8'h00)); run_burst("rd10");

    for (int i = 0; i < 5; i++) q.push_back(mk(1, 8'(i), 8'(8'h11 + i)));
    run_burst("b2b_wr");
    for (int i = 0; i < 5; i++) q.push_back(mk(0, 8'(i), 8'h00));
    run_burst("b2b_rd");

    q.push_back(mk(1, 8'hFF, 8'h3C)); q.push_back(mk(0, 8'hFF, 8'h00));
    run_burst("wr_rd_ff");
    q.push_back(mk(0, 8'h20, 8'h00)); run_burst("rd_unwritten");

    // Random bursts with a small address pool to force write/read collisions.
    for (int b = 0; b < 12; b++) begin
      int len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        q.push_back(mk(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                             : pool[$urandom_range(0, 5)],
                       8'($urandom)));
      run_burst("rand");
    end

    // Reset during the ACCESS phase of a write to 0x40.
    @(negedge pclk);
    drive(mk(1, 8'h40, 8'h99));
    @(posedge pclk); #1;
    transfer = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    mdl_reset();
    #1;
    chk("midrst_pready", pready, 1'b0);
    chk("midrst_prdata", prdata, 8'h00);
    @(posedge pclk); #1;
    chk("midrst_hold_rdy", pready, 1'b0);
    @(negedge pclk); preset = 1'b1;
    q.push_back(mk(0, 8'h40, 8'h00)); q.push_back(mk(0, 8'h10, 8'h00));
    q.push_back(mk(0, 8'hFF, 8'h00));
    run_burst("after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/apb_top_module.md
Name: apb_top_module

Overview:
- Self-contained APB subsystem: an APB master FSM driving an internal APB slave with a 256x8 register-file memory.
- The user side issues single read/write requests via `transfer` / `read_write`.
- The block returns `pready` per completed access and `prdata` with the last read value.
- Used as a protocol demonstrator and bus-functional endpoint in APB test environments.

Parameters:
- ADDR_WIDTH, 8, width of address buses; memory depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, width of write/read data.
- WAIT_STATES, 2, slave wait cycles per access. Used only when APB_WAIT_STATE_EN is defined.

Ports:
- pclk  input  1  APB clock; all state changes on rising edge.
- preset  input  1  reset, asynchronous, active-low (0 = reset).
- transfer  input  1  request; high = start/continue transfers.
- read_write  input  1  1 = write, 0 = read.
- apb_write_paddr  input  ADDR_WIDTH  target address for writes.
- apb_write_data  input  DATA_WIDTH  write data.
- apb_read_paddr  input  ADDR_WIDTH  target address for reads.
- pready  output  1  slave ready; high in the completing ACCESS cycle.
- prdata  output  DATA_WIDTH  registered read data of the last completed read.

Behaviour:
- **Clocking and reset**
  - Single clock, pclk.
  - preset low asynchronously forces:
    - master state = IDLE, internal psel = 0, penable = 0
    - pready = 0, prdata = 0
    - all memory locations = 0, wait counter = 0
- **Master FSM states**
  - IDLE: psel = 0, penable = 0.
    - transfer = 1 at a rising edge -> SETUP; else stay IDLE.
  - SETUP: psel = 1, penable = 0. Always -> ACCESS on the next edge.
  - ACCESS: psel = 1, penable = 1.
    - pready = 0 -> stay in ACCESS.
    - pready = 1 and transfer = 1 -> SETUP (back-to-back transfer).
    - pready = 1 and transfer = 0 -> IDLE.
- **Request capture**
  - On the IDLE->SETUP and ACCESS->SETUP edges, the master registers:
    - pwrite = read_write
    - paddr = read_write ? apb_write_paddr : apb_read_paddr
    - pwdata = apb_write_data
  - Input changes after capture are ignored until the next SETUP.
  - Dropping transfer during SETUP or ACCESS does not abort the transfer in flight.
- **Slave**
  - pready = psel & penable & wait_done; combinational, so it is 0 outside ACCESS.
  - Without waits, wait_done = 1: every access completes in exactly 2 cycles (SETUP + ACCESS).
- **Completion**
  - At the rising edge where psel & penable & pready:
    - Write: mem[paddr] <= pwdata.
    - Read: prdata <= mem[paddr].
  - prdata holds its value until the next completed read; writes do not alter prdata.
- **Boundary conditions**
  - Addresses are full-range 0..2**ADDR_WIDTH-1; no out-of-range or error response.
  - Write followed immediately by a read of the same address returns the new data.
  - Reset asserted mid-transfer: the transfer is abandoned and no memory update occurs.

Optional Feature:
- Macro APB_WAIT_STATE_EN.
- When defined:
  - The slave counter starts at 0 on entry to ACCESS and increments each ACCESS cycle.
  - wait_done = (count == WAIT_STATES), so each access takes 2 + WAIT_STATES cycles.
  - pready stays low for WAIT_STATES cycles, then high for one cycle.
  - The counter clears on completion.
- When undefined: no counter logic; pready is high in the first ACCESS cycle.

Test Plan:
- Reset low for 1 cycle, then high -> pready = 0, prdata = 0x00, FSM IDLE.
- Write then read:
  - Write: transfer = 1, read_write = 1, addr 0x10, data 0xA5 for 1 transfer -> pready pulses in the ACCESS cycle; mem[0x10] = 0xA5.
  - Read: transfer = 1, read_write = 0, read addr 0x10 -> prdata = 0xA5 after the ACCESS edge.
- Hold transfer = 1 for 5 writes (0x00..0x04 with data 0x11..0x15) -> SETUP/ACCESS alternate with no IDLE gap. Reads of 0x00..0x04 then return 0x11..0x15.
- Boundary addresses:
  - Write 0xFF -> 0x3C, then read 0xFF -> prdata = 0x3C.
  - Read never-written address 0x20 -> prdata = 0x00.
- Assert reset during ACCESS of a write to 0x40 -> FSM IDLE, pready = 0; a subsequent read of 0x40 returns 0x00.
- With APB_WAIT_STATE_EN and WAIT_STATES = 2 -> each access spans 4 cycles; pready is high only in the 4th cycle; data checks from the write/read scenario still pass.
